mips_muldiv: RTL and testbench
==============================

# mips_muldiv

Iterative multiply/divide unit that owns the HI/LO register pair for the MIPS core. It executes MULT/MULTU/DIV/DIVU in 34 cycles and MTHI/MTLO in one cycle. It sits beside the ALU: the ALU/decode stage issues operations over a valid/ready handshake, and reads HI/LO back for MFHI/MFLO. It frees the ALU from the single-cycle combinational 64-bit multiply and 32-bit divide.

## Interface
- No parameters; widths fixed at 32/64.
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- op_valid  in  1  operation request
- op_ready  out  1  unit can accept; equals !busy
- op  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, others reserved
- src_a  in  32  multiplicand / dividend / MTHI-MTLO data
- src_b  in  32  multiplier / divisor
- busy  out  1  iterative operation in progress
- done  out  1  one-cycle pulse: HI/LO just updated
- hi  out  32  architectural HI
- lo  out  32  architectural LO

## Operation
- Handshake: accept when op_valid && op_ready at a rising edge. src_a, src_b and op are captured at that edge and may change afterwards. Requests while busy are ignored, not queued.
- Reserved op codes: accepted, no state change, no done.
- MTHI/MTLO: hi (resp. lo) <= src_a at the accept edge. done pulses the following cycle. busy never asserts.
- FSM: IDLE -> CALC (32 iterations, 5-bit counter) -> FIX -> IDLE.
- CALC, multiply: shift-add on operand magnitudes, one bit per cycle, 64-bit accumulator.
- CALC, divide: restoring, one quotient bit per cycle, 33-bit partial remainder.
- Signed ops use magnitudes in CALC; FIX applies the sign:
  - product negated if signs differ;
  - quotient negated if signs differ;
  - remainder takes the sign of the dividend.
- Unsigned ops treat operands as raw 32-bit values.
- FIX writes {hi, lo}: MULT/MULTU write the 64-bit product; DIV/DIVU write HI = remainder and LO = quotient.
- Divide by zero (src_b == 0, signed or unsigned): full latency, HI = src_a as captured, LO = 32'hFFFF_FFFF.
- Signed overflow 0x8000_0000 / 0xFFFF_FFFF: LO = 0x8000_0000, HI = 0.
- hi/lo hold their previous values throughout CALC. Working registers are internal and never visible.

## Timing
- Reset (async assert, sync release): state IDLE, hi = 0, lo = 0, busy = 0, done = 0, op_ready = 1.
- Accept at edge E0. busy is high from after E0 until after E33; CALC spans E1..E32. FIX at E33 updates hi/lo, drops busy and raises done for one cycle.
- Result latency: 33 edges after accept. The next op can be accepted at E33 + 1 at the earliest, i.e. the edge at which done is observed high.
- MTHI/MTLO followed by another request on the next edge is legal with no bubble.
- Reset asserted mid-CALC or mid-FIX: the operation is abandoned, all outputs take reset values immediately, and no done is produced.
- done and busy never assert in the same cycle.

## Structure
- Shared package mips_pkg:
  - muldiv_op_t enum (the op encodings above);
  - muldiv_state_t (IDLE, CALC, FIX);
  - constant MULDIV_ITER = 32.
- Single module; no sub-module. Helper functions for magnitude and conditional negate live in mips_pkg for reuse.

## Test plan
- MULTU 0xFFFF_FFFF × 0xFFFF_FFFF -> hi = 0xFFFF_FFFE, lo = 0x0000_0001. done exactly 33 edges after accept; busy high for 33 cycles.
- MULT 0xFFFF_FFFD (−3) × 5 -> hi = 0xFFFF_FFFF, lo = 0xFFFF_FFF1.
- DIV −7 / 2 -> lo = 0xFFFF_FFFD, hi = 0xFFFF_FFFF. DIVU 7 / 2 -> lo = 3, hi = 1.
- Divide edge cases:
  - DIV 0x8000_0000 / 0xFFFF_FFFF -> lo = 0x8000_0000, hi = 0;
  - DIVU 5 / 0 -> hi = 5, lo = 0xFFFF_FFFF.
- Back-to-back and ignored requests:
  - MTHI 0x1234_5678 -> hi updated next edge, done pulse;
  - then MTLO 0xCAFE_F00D on the following edge -> lo updated, no bubble;
  - a MULT issued while busy is ignored (hi/lo unchanged by it, only one done).
- MULTU 3 × 4 with rst_n pulsed low at cycle 10 -> hi = lo = 0 and busy = 0 immediately. No done follows; op_ready = 1 after release.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: multiply/divide op encodings, FSM states and
// sign helpers used by the iterative HI/LO unit.
package mips_pkg;

    localparam int MULDIV_ITER = 32;

    typedef enum logic [2:0] {
        OP_MULT  = 3'b000,
        OP_MULTU = 3'b001,
        OP_DIV   = 3'b010,
        OP_DIVU  = 3'b011,
        OP_MTHI  = 3'b100,
        OP_MTLO  = 3'b101
    } muldiv_op_t;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX
    } muldiv_state_t;

    function automatic logic [31:0] mag32(input logic [31:0] x, input logic is_signed);
        return (is_signed && x[31]) ? (~x + 32'd1) : x;
    endfunction

    function automatic logic [31:0] cneg32(input logic [31:0] x, input logic neg);
        return neg ? (~x + 32'd1) : x;
    endfunction

    function automatic logic [63:0] cneg64(input logic [63:0] x, input logic neg);
        return neg ? (~x + 64'd1) : x;
    endfunction

endpackage

// File: rtl/mips_muldiv.sv
// Iterative multiply/divide unit owning HI/LO: shift-add multiply and restoring
// divide on operand magnitudes over 32 cycles, with a final sign-fix cycle.
module mips_muldiv
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        op_valid,
    output logic        op_ready,
    input  logic [2:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    muldiv_state_t r_state;
    logic [4:0]    r_cnt;
    logic          r_is_div;
    logic          r_neg_res;
    logic          r_neg_rem;
    logic          r_div_zero;
    logic [31:0]   r_src_a;
    logic [31:0]   r_rem;      // multiply: upper product half; divide: partial remainder
    logic [31:0]   r_work_lo;  // multiply: multiplier/lower half; divide: dividend/quotient
    logic [31:0]   r_opb;
    logic [31:0]   r_hi;
    logic [31:0]   r_lo;
    logic          r_busy;
    logic          r_done;

    muldiv_op_t    w_op;
    logic          w_signed;
    logic [32:0]   w_mul_sum;
    logic [32:0]   w_div_shift;
    logic          w_div_ge;
    logic [31:0]   w_div_diff;
    logic [63:0]   w_product;
    logic [31:0]   w_quo;
    logic [31:0]   w_remv;

    assign w_op     = muldiv_op_t'(op);
    assign w_signed = ~op[0];

    assign w_mul_sum   = {1'b0, r_rem} + {1'b0, (r_work_lo[0] ? r_opb : 32'd0)};
    // The top bit of the shifted remainder takes part in the compare; when the
    // trial succeeds the true difference fits in 32 bits, so wrap-around is exact.
    assign w_div_shift = {r_rem, r_work_lo[31]};
    assign w_div_ge    = (w_div_shift >= {1'b0, r_opb});
    assign w_div_diff  = w_div_shift[31:0] - r_opb;

    assign w_product = cneg64({r_rem, r_work_lo}, r_neg_res);
    assign w_quo     = cneg32(r_work_lo, r_neg_res);
    assign w_remv    = cneg32(r_rem, r_neg_rem);

    // NOTE: every register here, working state included, uses non-blocking
    // assignment and is cleared by the async reset so an abandoned op leaves no residue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_is_div   <= 1'b0;
            r_neg_res  <= 1'b0;
            r_neg_rem  <= 1'b0;
            r_div_zero <= 1'b0;
            r_src_a    <= '0;
            r_rem      <= '0;
            r_work_lo  <= '0;
            r_opb      <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (op_valid) begin
                        case (w_op)
                            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                                r_state    <= CALC;
                                r_busy     <= 1'b1;
                                r_cnt      <= '0;
                                r_is_div   <= op[1];
                                r_neg_res  <= w_signed && (src_a[31] ^ src_b[31]);
                                r_neg_rem  <= w_signed && src_a[31];
                                r_div_zero <= (src_b == 32'd0);
                                r_src_a    <= src_a;
                                r_rem      <= '0;
                                r_work_lo  <= mag32(src_a, w_signed);
                                r_opb      <= mag32(src_b, w_signed);
                            end
                            OP_MTHI: begin
                                r_hi   <= src_a;
                                r_done <= 1'b1;
                            end
                            OP_MTLO: begin
                                r_lo   <= src_a;
                                r_done <= 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
                CALC: begin
                    if (r_is_div) begin
                        r_rem     <= w_div_ge ? w_div_diff : w_div_shift[31:0];
                        r_work_lo <= {r_work_lo[30:0], w_div_ge};
                    end else begin
                        r_rem     <= w_mul_sum[32:1];
                        r_work_lo <= {w_mul_sum[0], r_work_lo[31:1]};
                    end
                    r_cnt <= r_cnt + 5'd1;
                    if (r_cnt == 5'(MULDIV_ITER - 1)) begin
                        r_state <= FIX;
                    end
                end
                FIX: begin
                    if (!r_is_div) begin
                        r_hi <= w_product[63:32];
                        r_lo <= w_product[31:0];
                    end else if (r_div_zero) begin
                        r_hi <= r_src_a;
                        r_lo <= 32'hFFFF_FFFF;
                    end else begin
                        r_hi <= w_remv;
                        r_lo <= w_quo;
                    end
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign op_ready = ~r_busy;
    assign busy     = r_busy;
    assign done     = r_done;
    assign hi       = r_hi;
    assign lo       = r_lo;

endmodule

// File: tb/tb_mips_muldiv.sv
// Scoreboard bench for mips_muldiv: directed ops push expected HI/LO, a
// negedge monitor pops and compares on every done pulse.
module tb_mips_muldiv;

    logic        clk;
    logic        rst_n;
    logic        op_valid;
    logic        op_ready;
    logic [2:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    typedef struct {
        string       name;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_done   = 0;
    int   n_pushed = 0;

    mips_muldiv dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .op_valid (op_valid),
        .op_ready (op_ready),
        .op       (op),
        .src_a    (src_a),
        .src_b    (src_b),
        .busy     (busy),
        .done     (done),
        .hi       (hi),
        .lo       (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (rst_n && done) begin
            exp_t e;
            n_done++;
            check("done_busy_exclusive", {31'd0, busy}, 32'd0);
            if (sb_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_done: got done with hi=0x%08h lo=0x%08h expected no done", hi, lo);
            end else begin
                e = sb_q.pop_front();
                check({e.name, "_hi"}, hi, e.hi);
                check({e.name, "_lo"}, lo, e.lo);
            end
        end
    end

    task automatic wait_ready();
        int t = 0;
        while (!op_ready && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        check("op_ready_before_issue", {31'd0, op_ready}, 32'd1);
    endtask

    // Returns 1 time unit after the accept edge.
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input bit push, input string name,
                         input logic [31:0] eh, input logic [31:0] el);
        exp_t e;
        wait_ready();
        op = o; src_a = a; src_b = b; op_valid = 1'b1;
        @(posedge clk);
        if (push) begin
            e.name = name; e.hi = eh; e.lo = el;
            sb_q.push_back(e);
            n_pushed++;
        end
        #1;
        op_valid = 1'b0;
        src_a = 32'hDEAD_BEEF; src_b = 32'hDEAD_BEEF;
    endtask

    task automatic drain();
        int t = 0;
        while (sb_q.size() != 0 && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        check("scoreboard_drained", sb_q.size(), 32'd0);
    endtask

    initial begin
        int busy_cnt;
        int done_edge;
        int saved_done;

        rst_n = 1'b0; op_valid = 1'b0; op = 3'd0; src_a = '0; src_b = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_op_ready", {31'd0, op_ready}, 32'd1);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // MULTU with latency and busy-duration measurement
        issue(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, "multu_max", 32'hFFFF_FFFE, 32'h0000_0001);
        busy_cnt  = int'(busy);
        done_edge = 0;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk); #1;
            if (done) begin
                done_edge = k;
                break;
            end
            busy_cnt += int'(busy);
        end
        check("multu_done_latency", done_edge, 32'd33);
        check("multu_busy_cycles", busy_cnt, 32'd33);
        drain();

        issue(3'b000, 32'hFFFF_FFFD, 32'd5,         1, "mult_neg3x5",   32'hFFFF_FFFF, 32'hFFFF_FFF1);
        drain();
        issue(3'b000, 32'hFFFF_FFFD, 32'hFFFF_FFFB, 1, "mult_neg3xneg5", 32'h0000_0000, 32'h0000_000F);
        drain();
        issue(3'b010, 32'hFFFF_FFF9, 32'd2,         1, "div_neg7_2",    32'hFFFF_FFFF, 32'hFFFF_FFFD);
        drain();
        issue(3'b010, 32'd7,         32'hFFFF_FFFE, 1, "div_7_neg2",    32'h0000_0001, 32'hFFFF_FFFD);
        drain();
        issue(3'b011, 32'd7,         32'd2,         1, "divu_7_2",      32'h0000_0001, 32'h0000_0003);
        drain();
        issue(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 1, "div_overflow",  32'h0000_0000, 32'h8000_0000);
        drain();
        issue(3'b011, 32'd5,         32'd0,         1, "divu_by_zero",  32'h0000_0005, 32'hFFFF_FFFF);
        drain();

        // MTHI then MTLO with no bubble
        issue(3'b100, 32'h1234_5678, 32'd0, 1, "mthi", 32'h1234_5678, 32'hFFFF_FFFF);
        issue(3'b101, 32'hCAFE_F00D, 32'd0, 1, "mtlo", 32'h1234_5678, 32'hCAFE_F00D);
        check("mtlo_no_bubble_lo", lo, 32'hCAFE_F00D);
        drain();

        // Reserved op: no state change, no done
        saved_done = n_done;
        issue(3'b111, 32'h5555_5555, 32'h6666_6666, 0, "", 32'd0, 32'd0);
        repeat (5) @(posedge clk);
        #1;
        check("reserved_hi", hi, 32'h1234_5678);
        check("reserved_lo", lo, 32'hCAFE_F00D);
        check("reserved_busy", {31'd0, busy}, 32'd0);
        check("reserved_no_done", n_done, saved_done);

        // Request while busy is ignored; hi/lo hold during CALC
        issue(3'b001, 32'd16, 32'd16, 1, "multu_16x16", 32'h0000_0000, 32'h0000_0100);
        repeat (5) @(posedge clk);
        #1;
        op = 3'b000; src_a = 32'd2; src_b = 32'd3; op_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        op_valid = 1'b0;
        check("calc_hold_hi", hi, 32'h1234_5678);
        check("calc_hold_lo", lo, 32'hCAFE_F00D);
        drain();
        saved_done = n_done;
        repeat (45) @(posedge clk);
        #1;
        check("ignored_no_extra_done", n_done, saved_done);

        // Reset mid-CALC abandons the op
        issue(3'b001, 32'd3, 32'd4, 0, "", 32'd0, 32'd0);
        repeat (9) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_hi", hi, 32'd0);
        check("midrst_lo", lo, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_done", {31'd0, done}, 32'd0);
        saved_done = n_done;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        check("midrst_no_done", n_done, saved_done);
        check("midrst_op_ready", {31'd0, op_ready}, 32'd1);
        check("midrst_hi_after", hi, 32'd0);

        check("total_done_pulses", n_done, n_pushed);
        check("scoreboard_empty", sb_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
